encoder_4_to_2: RTL and testbench
=================================

Name: encoder_4_to_2

Overview:
- Registered 4-to-2 priority encoder: four single-bit request lines in, a 2-bit binary index out.
- Adds a "valid" flag (any request active) and a "multi" flag (more than one request active).
- Used wherever a small set of one-hot or near-one-hot request lines must be turned into a binary select/index for downstream muxing or status logic.
- All outputs are registered on clk and cleared by a synchronous active-high reset.

Parameters:
- PRIORITY_HIGH, default 1: 1 = highest-numbered active input wins (in3 > in2 > in1 > in0); 0 = lowest-numbered active input wins (in0 > in1 > in2 > in3).

Ports:
- clk    input   1  clock; all state updates on rising edge
- rst    input   1  synchronous reset, active-high
- en     input   1  capture enable; when 0, output registers hold
- in0    input   1  request line 0 (index 0)
- in1    input   1  request line 1 (index 1)
- in2    input   1  request line 2 (index 2)
- in3    input   1  request line 3 (index 3)
- out0   output  1  encoded index bit 0 (LSB)
- out1   output  1  encoded index bit 1 (MSB)
- valid  output  1  1 when at least one input was active at capture
- multi  output  1  1 when two or more inputs were active at capture

Behaviour:
- Reset:
  - On a rising clk edge with rst=1, out1, out0, valid and multi all become 0.
  - rst has priority over en.
  - rst is sampled only at clk edges (synchronous); asserting it mid-cycle has no effect until the next edge.
- Combinational encode, computed from the current inputs:
  - Index of the winning active input per PRIORITY_HIGH, as a 2-bit value {out1,out0}.
  - Index mapping: in0 -> 00, in1 -> 01, in2 -> 10, in3 -> 11.
  - No input active: index = 00, valid = 0, multi = 0.
  - valid = OR of all four inputs.
  - multi = 1 when the population count of {in3,in2,in1,in0} is at least 2.
- Register update, on a rising clk edge with rst=0:
  - en=1: out1, out0, valid and multi load the combinational results.
  - en=0: all four outputs hold their previous values.
- Latency: exactly 1 clock from input sample to output; throughput of one new encode per cycle.
- Ambiguous all-zero vs in0-only case:
  - Both give index 00.
  - Downstream logic must qualify the index with valid (valid=0 vs valid=1).
- Multiple active inputs, PRIORITY_HIGH=1:
  - in1=1 and in2=1 -> index 10, multi=1.
  - All four active -> index 11, multi=1.
- Multiple active inputs, PRIORITY_HIGH=0:
  - in1=1 and in2=1 -> index 01, multi=1.
  - All four active -> index 00, valid=1, multi=1.
- Inputs are assumed synchronous to clk; no internal synchronizers.
- No X propagation requirement beyond standard two-state behaviour. After the first reset edge, outputs must never be X.

Test Plan:
- Reset check: rst=1 for 2 cycles with inputs 1111 and en=1 -> out1,out0,valid,multi = 0,0,0,0 after each edge. Release rst; next edge -> outputs 1,1,1,1 (PRIORITY_HIGH=1).
- Single-hot sweep (en=1, PRIORITY_HIGH=1):
  - 0000 -> {out1,out0}=00, valid=0, multi=0.
  - 0001 -> 00, valid=1, multi=0.
  - 0010 -> 01, valid=1, multi=0.
  - 0100 -> 10, valid=1, multi=0.
  - 1000 -> 11, valid=1, multi=0.
  - Each result appears exactly one edge after the inputs are applied.
- Priority with PRIORITY_HIGH=1: in={in3..in0}=0110 -> 10, valid=1, multi=1. 1111 -> 11, multi=1. 0011 -> 01, multi=1.
- Priority with PRIORITY_HIGH=0 (second instance): 0110 -> 01, multi=1. 1100 -> 10, multi=1. 1111 -> 00, valid=1, multi=1.
- Enable hold: capture 0100 (-> 10), then set en=0 and apply 1000 for 3 cycles -> outputs stay 10/valid=1/multi=0. Set en=1 -> next edge gives 11.
- Reset mid-stream: streaming 1000 with en=1, assert rst for one edge -> outputs 0 on that edge. Deassert rst -> next edge restores 11/valid=1. Separately, assert rst while en=0 -> outputs still clear.

Source files
------------

// File: rtl/encoder_4_to_2.sv
// rtl/encoder_4_to_2.sv - registered 4-to-2 priority encoder with valid and multi flags
module encoder_4_to_2 #(
  parameter int PRIORITY_HIGH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic out0,
  output logic out1,
  output logic valid,
  output logic multi
);

  logic [3:0] w_req;
  logic [1:0] w_idx;
  logic       w_valid;
  logic       w_multi;

  logic [1:0] r_idx;
  logic       r_valid;
  logic       r_multi;

  assign w_req = {in3, in2, in1, in0};

  // Winning index: the priority direction is fixed at elaboration; no request gives 00.
  always_comb begin
    w_idx = 2'b00;
    if (PRIORITY_HIGH != 0) begin
      if (w_req[3])      w_idx = 2'b11;
      else if (w_req[2]) w_idx = 2'b10;
      else if (w_req[1]) w_idx = 2'b01;
      else               w_idx = 2'b00;
    end else begin
      if (w_req[0])      w_idx = 2'b00;
      else if (w_req[1]) w_idx = 2'b01;
      else if (w_req[2]) w_idx = 2'b10;
      else if (w_req[3]) w_idx = 2'b11;
      else               w_idx = 2'b00;
    end
  end

  // Any request qualifies the index; any pair of requests means more than one is active.
  always_comb begin
    w_valid = |w_req;
    w_multi = (w_req[0] & w_req[1]) | (w_req[0] & w_req[2]) | (w_req[0] & w_req[3]) |
              (w_req[1] & w_req[2]) | (w_req[1] & w_req[3]) | (w_req[2] & w_req[3]);
  end

  // Output registers: reset clears, enable captures, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= 2'b00;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else if (en) begin
      r_idx   <= w_idx;
      r_valid <= w_valid;
      r_multi <= w_multi;
    end
  end

  assign out0  = r_idx[0];
  assign out1  = r_idx[1];
  assign valid = r_valid;
  assign multi = r_multi;

endmodule

// File: tb/tb_encoder_4_to_2.sv
// tb/tb_encoder_4_to_2.sv - randomized self-checking bench for encoder_4_to_2
module tb_encoder_4_to_2;

  logic clk;
  logic rst;
  logic en;
  logic in0, in1, in2, in3;
  logic h_out0, h_out1, h_valid, h_multi;
  logic l_out0, l_out1, l_valid, l_multi;

  int n_checks;
  int n_fail;

  logic [3:0] exp_h;
  logic [3:0] exp_l;
  logic [3:0] obs_h;
  logic [3:0] obs_l;

  encoder_4_to_2 #(.PRIORITY_HIGH(1)) u_dut_hi (
    .clk(clk), .rst(rst), .en(en),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out0(h_out0), .out1(h_out1), .valid(h_valid), .multi(h_multi)
  );

  encoder_4_to_2 #(.PRIORITY_HIGH(0)) u_dut_lo (
    .clk(clk), .rst(rst), .en(en),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out0(l_out0), .out1(l_out1), .valid(l_valid), .multi(l_multi)
  );

  assign obs_h = {h_out1, h_out0, h_valid, h_multi};
  assign obs_l = {l_out1, l_out0, l_valid, l_multi};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan the requests, count them, pick first or last active index.
  function automatic logic [3:0] ref_enc(input logic [3:0] v, input bit hi);
    int cnt;
    int idx;
    cnt = 0;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        cnt = cnt + 1;
        if (hi || cnt == 1) idx = i;
      end
    end
    return {idx[1:0], (cnt > 0) ? 1'b1 : 1'b0, (cnt >= 2) ? 1'b1 : 1'b0};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got {out1,out0,valid,multi}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, check both instances.
  task automatic step(input string tag, input logic r, input logic e, input logic [3:0] v);
    rst = r;
    en  = e;
    {in3, in2, in1, in0} = v;
    @(posedge clk);
    if (r) begin
      exp_h = 4'b0000;
      exp_l = 4'b0000;
    end else if (e) begin
      exp_h = ref_enc(v, 1'b1);
      exp_l = ref_enc(v, 1'b0);
    end
    #1;
    check({tag, "_hi"}, obs_h, exp_h);
    check({tag, "_lo"}, obs_l, exp_l);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_h    = 4'b0000;
    exp_l    = 4'b0000;
    rst = 1'b1;
    en  = 1'b1;
    {in3, in2, in1, in0} = 4'b1111;
    #1;

    // Reset with all requests active, then release.
    step("rst0", 1'b1, 1'b1, 4'b1111);
    check("rst0_const", obs_h, 4'b0000);
    step("rst1", 1'b1, 1'b1, 4'b1111);
    check("rst1_const", obs_h, 4'b0000);
    step("rel", 1'b0, 1'b1, 4'b1111);
    check("rel_const_hi", obs_h, 4'b1111);
    check("rel_const_lo", obs_l, 4'b0011);

    // Single-hot sweep including the all-zero case.
    step("none", 1'b0, 1'b1, 4'b0000);
    check("none_const", obs_h, 4'b0000);
    step("hot0", 1'b0, 1'b1, 4'b0001);
    check("hot0_const", obs_h, 4'b0010);
    step("hot1", 1'b0, 1'b1, 4'b0010);
    check("hot1_const", obs_h, 4'b0110);
    step("hot2", 1'b0, 1'b1, 4'b0100);
    check("hot2_const", obs_h, 4'b1010);
    step("hot3", 1'b0, 1'b1, 4'b1000);
    check("hot3_const", obs_h, 4'b1110);

    // Multiple requests, both priority directions.
    step("m0110", 1'b0, 1'b1, 4'b0110);
    check("m0110_hi_const", obs_h, 4'b1011);
    check("m0110_lo_const", obs_l, 4'b0111);
    step("m0011", 1'b0, 1'b1, 4'b0011);
    check("m0011_hi_const", obs_h, 4'b0111);
    step("m1100", 1'b0, 1'b1, 4'b1100);
    check("m1100_lo_const", obs_l, 4'b1011);
    step("m1111", 1'b0, 1'b1, 4'b1111);
    check("m1111_lo_const", obs_l, 4'b0011);

    // Enable hold: capture 0100 then present 1000 with en low.
    step("cap", 1'b0, 1'b1, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 1'b0, 4'b1000);
      check("hold_const", obs_h, 4'b1010);
    end
    step("resume", 1'b0, 1'b1, 4'b1000);
    check("resume_const", obs_h, 4'b1110);

    // Mid-cycle rst pulse between edges must not disturb the registers.
    rst = 1'b1;
    #2;
    check("rst_glitch_hi", obs_h, exp_h);
    rst = 1'b0;
    #1;

    // Reset mid-stream, then recovery; reset while disabled.
    step("mrst", 1'b1, 1'b1, 4'b1000);
    check("mrst_const", obs_h, 4'b0000);
    step("mrec", 1'b0, 1'b1, 4'b1000);
    check("mrec_const", obs_h, 4'b1110);
    step("rst_en0", 1'b1, 1'b0, 4'b1000);
    check("rst_en0_const", obs_h, 4'b0000);

    // Randomized traffic with occasional reset and enable drops.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
